// File: rtl/param_data_memory.sv
// Word-addressed data memory with byte-lane writes and a power-up sweep that
// loads word i with the value i before any request is accepted.
module param_data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    memWrite,
  input  logic                    memRead,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic [DATA_WIDTH/8-1:0] byteEnable,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic                    readValid,
  output logic                    busy,
  output logic                    addrError
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W       = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(DEPTH - 1);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } stateT;

  stateT            stateReg, stateNext;
  logic [IDX_W-1:0] initCountReg, initCountNext;
  logic             initWrite;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wordIndex;
  logic [IDX_W-1:0]      memIndex;
  logic                  misaligned;
  logic                  inRange;
  logic                  request;
  logic                  reject;
  logic                  acceptRead;
  logic                  acceptWrite;
  logic [DATA_WIDTH-1:0] currentWord;
  logic [DATA_WIDTH-1:0] mergedWord;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      stateReg     <= INIT;
      initCountReg <= '0;
    end else begin
      stateReg     <= stateNext;
      initCountReg <= initCountNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    initCountNext = initCountReg;
    busy          = 1'b0;
    initWrite     = 1'b0;
    case (stateReg)
      INIT: begin
        busy = 1'b1;
        // Hold the sweep off while reset is low so word 0 is not touched.
        initWrite     = reset;
        initCountNext = initCountReg + IDX_W'(1);
        if (initCountReg == LAST_IDX) begin
          stateNext     = READY;
          initCountNext = '0;
        end
      end
      READY: begin
        stateNext = READY;
      end
      default: begin
        stateNext = INIT;
      end
    endcase
  end

  assign wordIndex   = address >> OFFSET_BITS;
  assign memIndex    = wordIndex[IDX_W-1:0];
  assign misaligned  = |(address & OFFSET_MASK);
  assign inRange     = wordIndex < DEPTH_LIMIT;
  assign request     = (stateReg == READY) && (memRead || memWrite);
  assign reject      = request && (misaligned || !inRange);
  assign acceptRead  = (stateReg == READY) && memRead && !misaligned && inRange;
  assign acceptWrite = (stateReg == READY) && memWrite && !misaligned && inRange;

  // Combinational read port: same-cycle read+write must see merged data.
  assign currentWord = mem[memIndex];

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : gLane
      assign mergedWord[8*gi +: 8] = byteEnable[gi] ? writeData[8*gi +: 8]
                                                    : currentWord[8*gi +: 8];
    end
  endgenerate

  // Storage is deliberately outside the reset domain; only the sweep rewrites it.
  always_ff @(posedge clock_in) begin
    if (initWrite) begin
      mem[initCountReg] <= DATA_WIDTH'(initCountReg);
    end else if (acceptWrite) begin
      mem[memIndex] <= mergedWord;
    end
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      readData  <= '0;
      readValid <= 1'b0;
      addrError <= 1'b0;
    end else begin
      readValid <= acceptRead;
      addrError <= reject;
      if (acceptRead) begin
        readData <= acceptWrite ? mergedWord : currentWord;
      end
    end
  end

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory: reference memory model plus a queue
// of expected read results popped whenever readValid is seen.
module tb_param_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        memWrite;
  logic        memRead;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [3:0]  byteEnable;
  logic [31:0] readData;
  logic        readValid;
  logic        busy;
  logic        addrError;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] modelMem[16];
  logic [31:0] lastRead;

  always #5 clk = ~clk;

  param_data_memory #(
    .DATA_WIDTH(32),
    .DEPTH(16),
    .ADDR_WIDTH(32)
  ) dut (
    .clock_in(clk),
    .reset(reset),
    .memWrite(memWrite),
    .memRead(memRead),
    .address(address),
    .writeData(writeData),
    .byteEnable(byteEnable),
    .readData(readData),
    .readValid(readValid),
    .busy(busy),
    .addrError(addrError)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every readValid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (readValid === 1'b1) begin
      if (expQ.size() == 0) check("spurious_readValid", 32'(readValid), 32'd0);
      else                  check("readData", readData, expQ.pop_front());
    end
  end

  task automatic clearInputs();
    memRead    = 1'b0;
    memWrite   = 1'b0;
    address    = '0;
    writeData  = '0;
    byteEnable = '0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] idx;
    logic [31:0] merged;
    logic        legal;
    logic        expErr;
    memRead    = rd;
    memWrite   = wr;
    address    = addr;
    writeData  = wdata;
    byteEnable = be;
    idx    = addr >> 2;
    legal  = (addr[1:0] == 2'b00) && (idx < 32'd16);
    expErr = (rd || wr) && !legal;
    merged = '0;
    if (legal) begin
      merged = modelMem[idx[3:0]];
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        modelMem[idx[3:0]] = merged;
      end
      if (rd) begin
        expQ.push_back(merged);
        lastRead = merged;
      end
    end
    @(posedge clk); #1;
    $display("t=%0t rd=%0b wr=%0b addr=0x%08h wdata=0x%08h be=%b -> readValid=%0b readData=0x%08h addrError=%0b",
             $time, rd, wr, addr, wdata, be, readValid, readData, addrError);
    check("addrError", 32'(addrError), 32'(expErr));
    if (rd && legal) check("readValid_pulse", 32'(readValid), 32'd1);
    if (!legal) begin
      check("readValid_on_reject", 32'(readValid), 32'd0);
      check("readData_held", readData, lastRead);
    end
  endtask

  task automatic idle();
    clearInputs();
    @(posedge clk); #1;
    check("readValid_idle", 32'(readValid), 32'd0);
    check("addrError_idle", 32'(addrError), 32'd0);
  endtask

  // Runs the 16 INIT cycles after reset release; optionally hammers word 0
  // with requests that must be ignored.
  task automatic sweep(input bit pokeWrites);
    for (int c = 1; c <= 16; c++) begin
      if (pokeWrites && c >= 2) begin
        memWrite   = 1'b1;
        memRead    = 1'b1;
        address    = 32'h0;
        writeData  = 32'hFFFF_FFFF;
        byteEnable = 4'hF;
      end
      @(posedge clk); #1;
      check($sformatf("busy_c%0d", c), 32'(busy), (c < 16) ? 32'd1 : 32'd0);
      check("readValid_init", 32'(readValid), 32'd0);
      check("addrError_init", 32'(addrError), 32'd0);
    end
    clearInputs();
    for (int i = 0; i < 16; i++) modelMem[i] = 32'(i);
    $display("t=%0t init sweep complete, busy=%0b", $time, busy);
  endtask

  initial begin
    reset    = 1'b0;
    lastRead = '0;
    clearInputs();
    for (int i = 0; i < 16; i++) modelMem[i] = 'x;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_readValid", 32'(readValid), 32'd0);
    check("rst_readData", readData, 32'd0);
    check("rst_addrError", 32'(addrError), 32'd0);

    // Release with a read already pending at 0x0.
    reset   = 1'b1;
    memRead = 1'b1;
    address = 32'h0;
    sweep(1'b0);

    access(1'b1, 1'b0, 32'h0,  32'h0, 4'h0); idle();
    access(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0); idle();

    access(1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101); idle();
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0); idle();

    access(1'b1, 1'b0, 32'h6,  32'h0, 4'h0); idle();
    access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF); idle();
    access(1'b1, 1'b1, 32'h42, 32'hCAFE_F00D, 4'hF); idle();
    access(1'b1, 1'b0, 32'h0,  32'h0, 4'h0); idle();

    access(1'b0, 1'b1, 32'hC, 32'hFFFF_FFFF, 4'b0000); idle();
    access(1'b1, 1'b0, 32'hC, 32'h0, 4'h0); idle();

    access(1'b1, 1'b1, 32'h4, 32'h1234_5678, 4'b1111); idle();

    // Re-enter INIT, abort the sweep at counter 7, then restart it.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("busy_at_cnt7", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    lastRead = '0;
    check("midinit_rst_busy", 32'(busy), 32'd1);
    check("midinit_rst_readData", readData, 32'd0);
    check("midinit_rst_readValid", 32'(readValid), 32'd0);
    $display("t=%0t reset asserted mid-init", $time);
    @(posedge clk); #1;
    reset = 1'b1;
    sweep(1'b1);

    access(1'b1, 1'b0, 32'h1C, 32'h0, 4'h0); idle();

    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    idle();
    idle();

    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter: DEPTH, default 16, number of words; SHALL be at least 2.
REQ-003 Parameter: ADDR_WIDTH, default 32, width of the byte address bus.
REQ-004 clock_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 memWrite  input  1  write request, sampled at the rising edge.
REQ-007 memRead  input  1  read request, sampled at the rising edge.
REQ-008 address  input  ADDR_WIDTH  byte address of the access.
REQ-009 writeData  input  DATA_WIDTH  write data.
REQ-010 byteEnable  input  DATA_WIDTH/8  per-byte write mask; bit k enables bits 8k+7..8k.
REQ-011 readData  output  DATA_WIDTH  registered read result.
REQ-012 readValid  output  1  one-cycle pulse marking new readData.
REQ-013 busy  output  1  high while the initialisation sweep runs.
REQ-014 addrError  output  1  one-cycle pulse for a rejected request.

Function
REQ-015 The FSM SHALL have exactly two states, INIT and READY.
REQ-016 Word index SHALL be address >> log2(DATA_WIDTH/8); offset SHALL be address bits log2(DATA_WIDTH/8)-1..0.
REQ-017 In INIT, one word SHALL be written per cycle from counter 0 to DEPTH-1, with word i = i zero-extended to DATA_WIDTH; busy SHALL be 1.
REQ-018 When the INIT counter reaches DEPTH-1, the FSM SHALL enter READY on the next edge; busy SHALL be 0 from that edge, so the first request is accepted DEPTH cycles after reset release.
REQ-019 In INIT, memRead and memWrite SHALL be ignored: no memory change, readValid 0, addrError 0.
REQ-020 In READY, a request SHALL be rejected when the offset is non-zero or the index is at least DEPTH.
REQ-021 A rejected request SHALL set addrError 1 for exactly the next cycle, leave the memory unchanged, hold readValid 0 and leave readData unchanged; read+write together SHALL give a single pulse.
REQ-022 An accepted write SHALL update only the byte lanes whose byteEnable bit is 1, at the sampling edge.
REQ-023 An accepted read SHALL load readData and pulse readValid for one cycle on the sampling edge (latency 1).
REQ-024 readData SHALL hold its value until the next accepted read.
REQ-025 memRead and memWrite to the same valid index in one cycle SHALL be write-first: readData returns old data merged with the enabled bytes of writeData.
REQ-026 Back-to-back accepted reads SHALL produce readValid high on consecutive cycles, with no bubble.
REQ-027 Words not written since the last INIT sweep SHALL retain their initialised values.
REQ-028 byteEnable all-zero with memWrite=1 to a valid address SHALL cause no memory change and no error.

Reset
REQ-029 Asserting reset (0) SHALL immediately force: state INIT, INIT counter 0, readData 0, readValid 0, addrError 0, busy 1.
REQ-030 Memory contents SHALL NOT be cleared by reset assertion itself; they SHALL be rewritten only by the following INIT sweep.
REQ-031 Reset asserted mid-INIT or mid-access SHALL abort the operation; after release the sweep SHALL restart at word 0.
REQ-032 Reset release SHALL take effect on the first rising clock_in edge after deassertion.

Verification (DATA_WIDTH=32, DEPTH=16)
REQ-033 Release reset, then hold memRead=1 at address 0x0: busy stays 1 for 16 cycles with readValid 0; the first read after busy falls returns 0x00000000. A read at 0x3C returns 0x0000000F.
REQ-034 Write 0xAABBCCDD, byteEnable 4'b0101, to 0x8 (initial value 0x00000002), then read 0x8 -> readData 0x00BB00DD one cycle later, readValid pulse 1 cycle.
REQ-035 Read 0x6 (misaligned) and, separately, write 0x40 (index 16) -> addrError one-cycle pulse each, readValid 0, readData unchanged, memory unchanged.
REQ-036 Same-cycle write 0x12345678, byteEnable 4'b1111, plus read, to 0x4 -> readData 0x12345678 on the next cycle.
REQ-037 Assert reset at INIT counter 7, release, then read 0x1C after busy falls -> busy high for a full 16 cycles again, readData 0x00000007.
REQ-038 Reads to 0x0, 0x4 and 0x8 on three consecutive cycles -> readValid high for 3 consecutive cycles, returning 0, 1 and 2.
